sa_output_arbiter: RTL and testbench
====================================

# sa_output_arbiter

Per-output-port switch allocator for the NoC router. It arbitrates wormhole packets from N_IN input virtual channels onto one output link, using round-robin on head flits and holding the grant until the packet's tail flit. It tracks downstream buffer space with credits and returns a per-input stop signal to the input buffers. It sits between the route-computation stage and the output link register, one instance per output port.

## Interface
- N_IN, 5, number of requesting inputs (2..8)
- FLIT_W, 32, flit width in bits
- DEPTH, 4, downstream buffer depth = initial credit count (1..15)

- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req_flit  input  N_IN*FLIT_W  flit offered by input i at bits [i*FLIT_W +: FLIT_W]
- req_type  input  2*N_IN  flit type for input i at [2*i +: 2]: 00 none, 01 head, 10 body, 11 tail
- credit_in  input  1  one-cycle pulse: downstream freed one slot
- stop  output  N_IN  combinational; stop[i]=0 means input i's flit is consumed this cycle
- out_flit  output  FLIT_W  registered output flit
- out_valid  output  1  registered; out_flit is valid this cycle
- locked  output  1  registered; 1 while a packet owns the output
- owner  output  3  registered index of the current/last granted input
- err  output  1  sticky protocol error flag

## Operation
- State: IDLE / LOCKED, rr_ptr (3b), owner (3b), credits (4b, 0..DEPTH).
- Transfer: input i transfers in a cycle iff stop[i]=0 and req_type[i]!=00. The flit and its type are registered on the next rising edge.
- IDLE:
  - If credits>0, scan inputs in order rr_ptr, rr_ptr+1, ... (mod N_IN) for the first input with type 01.
  - That input gets stop=0. All other inputs get stop=1.
  - On transfer: owner<=i and state<=LOCKED.
  - No head present, or credits==0: all stop=1, state, rr_ptr and owner unchanged.
  - Body/tail flits at an unlocked input are not granted; err<=1.
- LOCKED:
  - stop[owner]=0 iff credits>0 and req_type[owner] is 10 or 11. All other stop=1.
  - Type 00 from the owner is a bubble: the lock is held and nothing is sent.
  - Head (01) from the owner while locked: stop[owner]=1, not sent, err<=1.
  - Tail transfer: state<=IDLE and rr_ptr<=(owner+1) mod N_IN.
- Credits:
  - Each transfer decrements credits. Each credit_in pulse increments them.
  - Transfer and credit_in in the same cycle: count unchanged.
  - credit_in when credits==DEPTH with no transfer: saturate at DEPTH and set err<=1.
  - Credits never go below 0 because no grant is issued at 0.
- Output:
  - out_valid<=1 on a transfer cycle, else 0.
  - out_flit<=granted flit on transfer, else it holds its previous value.
- err is cleared only by reset.

## Timing
- Reset values: out_flit=0, out_valid=0, locked=0, owner=0, err=0, stop=all 1 (combinational from reset state with no heads), state=IDLE, rr_ptr=0, credits=DEPTH.
- Latency: a flit offered in cycle t (stop=0) appears on out_flit/out_valid in cycle t+1.
- Head and body flits from the same input are back-to-back capable: one flit per cycle while credits allow.
- Grant for a new packet can occur in the cycle immediately after a tail transfer, since the state is IDLE then.
- stop depends only on registered state and current req_type, with no combinational path from credit_in.
- Reset asserted mid-packet: the lock is dropped, credits return to DEPTH, and out_valid deasserts immediately (asynchronous).

## Test plan
- Reset, then inputs 0 and 2 present heads together -> input 0 granted (stop=5'b11110), out_valid at t+1, locked=1, owner=0.
- Input 0 sends head, body, tail (3 cycles) while input 2 holds its head -> input 2 waits with stop[2]=1 throughout; input 2 is granted in the cycle after the tail; rr_ptr=1.
- DEPTH=4 with no credit_in: a 6-flit packet -> 4 flits are sent, then stop[owner]=1 with credits=0. One credit_in pulse -> exactly one more flit is sent.
- credit_in in the same cycle as a transfer with credits=2 -> credits stays 2. credit_in at credits=4 -> credits stays 4 and err=1.
- While locked to input 1, input 1 presents type 01 -> not sent, err=1, lock held. Input 1 inserts a 00 bubble, then a tail -> the tail is sent and state returns to IDLE.
- Reset asserted two flits into a packet -> locked=0, out_valid=0, credits=DEPTH asynchronously. After reset deasserts, a fresh head from input 3 is granted.

Source files
------------

// File: rtl/sa_output_arbiter.sv
// sa_output_arbiter: per-output-port wormhole switch allocator.
// Round-robin on head flits, grant held to tail, credit-based flow control.
module sa_output_arbiter #(
    parameter int N_IN   = 5,
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IN*FLIT_W-1:0]   req_flit,
    input  logic [2*N_IN-1:0]        req_type,
    input  logic                     credit_in,
    output logic [N_IN-1:0]          stop,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_valid,
    output logic                     locked,
    output logic [2:0]               owner,
    output logic                     err
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [3:0] NIN_C   = 4'(N_IN);
    localparam logic [2:0] LAST_C  = 3'(N_IN - 1);

    state_t              r_state;
    logic [2:0]          r_rr_ptr;
    logic [2:0]          r_owner;
    logic [3:0]          r_credits;
    logic [FLIT_W-1:0]   r_out_flit;
    logic                r_out_valid;
    logic                r_err;

    logic                w_head_found;
    logic [2:0]          w_head_idx;
    logic [1:0]          w_own_type;
    logic                w_xfer;
    logic [2:0]          w_sel;
    logic [1:0]          w_sel_type;
    logic [FLIT_W-1:0]   w_sel_flit;
    logic                w_err_proto;
    logic                w_overflow;
    logic [N_IN-1:0]     w_stop;

    // Round-robin scan for the first head flit starting at rr_ptr
    always_comb begin : scan
        logic [3:0] idx;
        w_head_found = 1'b0;
        w_head_idx   = '0;
        idx          = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = {1'b0, r_rr_ptr} + 4'(k);
            if (idx >= NIN_C) begin
                idx = idx - NIN_C;
            end
            if (!w_head_found && req_type[2*idx +: 2] == 2'b01) begin
                w_head_found = 1'b1;
                w_head_idx   = idx[2:0];
            end
        end
    end

    // Grant decision, stop vector and protocol error detection
    always_comb begin
        w_own_type  = req_type[2*r_owner +: 2];
        w_xfer      = 1'b0;
        w_sel       = r_owner;
        w_err_proto = 1'b0;
        if (r_state == S_IDLE) begin
            w_sel  = w_head_idx;
            w_xfer = w_head_found && (r_credits != 4'd0);
            for (int i = 0; i < N_IN; i++) begin
                if (req_type[2*i+1]) begin
                    w_err_proto = 1'b1;
                end
            end
        end else begin
            w_xfer      = (r_credits != 4'd0) && w_own_type[1];
            w_err_proto = (w_own_type == 2'b01);
        end
        w_sel_type = req_type[2*w_sel +: 2];
        w_sel_flit = req_flit[int'(w_sel)*FLIT_W +: FLIT_W];
        w_overflow = credit_in && !w_xfer && (r_credits == DEPTH_C);
        w_stop     = '1;
        if (w_xfer) begin
            w_stop[w_sel] = 1'b0;
        end
    end

    // Allocation FSM with credit counter and registered output link
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_credits   <= DEPTH_C;
            r_out_flit  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_xfer;
            r_err       <= r_err | w_err_proto | w_overflow;
            if (w_xfer && !credit_in) begin
                r_credits <= r_credits - 4'd1;
            end else if (!w_xfer && credit_in && !w_overflow) begin
                r_credits <= r_credits + 4'd1;
            end
            if (w_xfer) begin
                r_out_flit <= w_sel_flit;
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_LOCKED;
                        r_owner <= w_sel;
                    end
                    S_LOCKED: begin
                        if (w_sel_type == 2'b11) begin
                            r_state  <= S_IDLE;
                            r_rr_ptr <= (r_owner == LAST_C) ? 3'd0
                                                            : r_owner + 3'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign stop      = w_stop;
    assign out_flit  = r_out_flit;
    assign out_valid = r_out_valid;
    assign locked    = (r_state == S_LOCKED);
    assign owner     = r_owner;
    assign err       = r_err;

endmodule

// File: tb/tb_sa_output_arbiter.sv
// tb_sa_output_arbiter: scenario-driven bench for sa_output_arbiter.
// Expected flits are queued on grant and compared when out_valid appears.
module tb_sa_output_arbiter;

    localparam int N = 5;
    localparam int W = 32;
    localparam int D = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*W-1:0]    req_flit;
    logic [2*N-1:0]    req_type;
    logic              credit_in;
    logic [N-1:0]      stop;
    logic [W-1:0]      out_flit;
    logic              out_valid;
    logic              locked;
    logic [2:0]        owner;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] sb[$];

    sa_output_arbiter #(.N_IN(N), .FLIT_W(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_flit  (req_flit),
        .req_type  (req_type),
        .credit_in (credit_in),
        .stop      (stop),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .locked    (locked),
        .owner     (owner),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every valid output must match the oldest expected flit
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_flit unexpected got=%h", out_flit);
            end else begin
                logic [W-1:0] e;
                e = sb.pop_front();
                if (out_flit !== e) begin
                    n_fail++;
                    $display("FAIL out_flit got=%h exp=%h", out_flit, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic set_in(input int i, input logic [1:0] t,
                          input logic [W-1:0] f);
        req_type[2*i +: 2] = t;
        req_flit[i*W +: W] = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        reset     = 1'b1;
        req_type  = '0;
        req_flit  = '0;
        credit_in = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        step();
        step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_outputs got=%0d exp=0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_type  = '0;
        req_flit  = '0;
        credit_in = 1'b0;
        #2;
        n_tests++;
        if ({out_valid, locked, owner, err} !== 6'b0 || out_flit !== '0) begin
            n_fail++;
            $display("FAIL reset_outs got=%b%b%0d%b %h exp=0",
                     out_valid, locked, owner, err, out_flit);
        end
        n_tests++;
        if (stop !== 5'b11111) begin
            n_fail++;
            $display("FAIL reset_stop got=%b exp=11111", stop);
        end
        n_tests++;
        if (dut.r_credits !== 4'(D)) begin
            n_fail++;
            $display("FAIL reset_credits got=%0d exp=%0d", dut.r_credits, D);
        end
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        apply_reset();
        credit_in = 1'b1;
        set_in(0, 2'b01, 32'hA000_0000);
        set_in(2, 2'b01, 32'hA200_0000);
        #1;
        n_tests++;
        if (stop !== 5'b11110) begin
            n_fail++;
            $display("FAIL rr_first_stop got=%b exp=11110", stop);
        end
        sb.push_back(32'hA000_0000);
        step();
        n_tests++;
        if (locked !== 1'b1 || owner !== 3'd0) begin
            n_fail++;
            $display("FAIL rr_lock got=%b/%0d exp=1/0", locked, owner);
        end
        set_in(0, 2'b10, 32'hB000_0001);
        #1;
        n_tests++;
        if (stop !== 5'b11110) begin
            n_fail++;
            $display("FAIL rr_body_stop got=%b exp=11110", stop);
        end
        sb.push_back(32'hB000_0001);
        step();
        set_in(0, 2'b11, 32'hC000_0002);
        #1;
        n_tests++;
        if (stop !== 5'b11110) begin
            n_fail++;
            $display("FAIL rr_tail_stop got=%b exp=11110", stop);
        end
        sb.push_back(32'hC000_0002);
        step();
        set_in(0, 2'b00, 32'h0);
        #1;
        n_tests++;
        if (locked !== 1'b0 || dut.r_rr_ptr !== 3'd1) begin
            n_fail++;
            $display("FAIL rr_after_tail got=%b/%0d exp=0/1",
                     locked, dut.r_rr_ptr);
        end
        n_tests++;
        if (stop !== 5'b11011) begin
            n_fail++;
            $display("FAIL rr_second_stop got=%b exp=11011", stop);
        end
        sb.push_back(32'hA200_0000);
        step();
        n_tests++;
        if (locked !== 1'b1 || owner !== 3'd2) begin
            n_fail++;
            $display("FAIL rr_second_lock got=%b/%0d exp=1/2", locked, owner);
        end
        set_in(2, 2'b11, 32'hC200_0001);
        #1;
        sb.push_back(32'hC200_0001);
        step();
        set_in(2, 2'b00, 32'h0);
        credit_in = 1'b0;
        #1;
        n_tests++;
        if (locked !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_end got=%b/%b exp=0/0", locked, err);
        end
        drain("rr");
    endtask

    task automatic test_credit_exhaust();
        apply_reset();
        set_in(1, 2'b01, 32'h1100_0000);
        #1;
        sb.push_back(32'h1100_0000);
        for (int k = 1; k < 4; k++) begin
            step();
            set_in(1, 2'b10, 32'h1100_0000 + k);
            #1;
            n_tests++;
            if (stop !== 5'b11101) begin
                n_fail++;
                $display("FAIL cr_body%0d_stop got=%b exp=11101", k, stop);
            end
            sb.push_back(32'h1100_0000 + k);
        end
        step();
        set_in(1, 2'b10, 32'h1100_0004);
        #1;
        n_tests++;
        if (stop !== 5'b11111 || dut.r_credits !== 4'd0) begin
            n_fail++;
            $display("FAIL cr_empty got=%b/%0d exp=11111/0",
                     stop, dut.r_credits);
        end
        step();
        credit_in = 1'b1;
        #1;
        n_tests++;
        if (stop !== 5'b11111) begin
            n_fail++;
            $display("FAIL cr_no_comb_credit got=%b exp=11111", stop);
        end
        step();
        credit_in = 1'b0;
        #1;
        n_tests++;
        if (stop !== 5'b11101) begin
            n_fail++;
            $display("FAIL cr_one_more got=%b exp=11101", stop);
        end
        sb.push_back(32'h1100_0004);
        step();
        set_in(1, 2'b11, 32'h1100_0005);
        #1;
        n_tests++;
        if (stop !== 5'b11111 || dut.r_credits !== 4'd0) begin
            n_fail++;
            $display("FAIL cr_stop_again got=%b/%0d exp=11111/0",
                     stop, dut.r_credits);
        end
        drain("credit");
    endtask

    task automatic test_credit_same_cycle();
        apply_reset();
        set_in(3, 2'b01, 32'h3300_0000);
        #1;
        sb.push_back(32'h3300_0000);
        step();
        set_in(3, 2'b10, 32'h3300_0001);
        #1;
        sb.push_back(32'h3300_0001);
        step();
        n_tests++;
        if (dut.r_credits !== 4'd2) begin
            n_fail++;
            $display("FAIL cs_two got=%0d exp=2", dut.r_credits);
        end
        set_in(3, 2'b10, 32'h3300_0002);
        credit_in = 1'b1;
        #1;
        sb.push_back(32'h3300_0002);
        step();
        n_tests++;
        if (dut.r_credits !== 4'd2) begin
            n_fail++;
            $display("FAIL cs_same_cycle got=%0d exp=2", dut.r_credits);
        end
        credit_in = 1'b0;
        set_in(3, 2'b11, 32'h3300_0003);
        #1;
        sb.push_back(32'h3300_0003);
        step();
        set_in(3, 2'b00, 32'h0);
        credit_in = 1'b1;
        step();
        step();
        step();
        n_tests++;
        if (dut.r_credits !== 4'd4 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_full got=%0d/%b exp=4/0", dut.r_credits, err);
        end
        step();
        n_tests++;
        if (dut.r_credits !== 4'd4 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL cs_overflow got=%0d/%b exp=4/1", dut.r_credits, err);
        end
        credit_in = 1'b0;
        drain("credit_same");
    endtask

    task automatic test_head_while_locked();
        apply_reset();
        set_in(1, 2'b01, 32'h5100_0000);
        #1;
        sb.push_back(32'h5100_0000);
        step();
        set_in(1, 2'b01, 32'h5100_00FF);
        #1;
        n_tests++;
        if (stop !== 5'b11111) begin
            n_fail++;
            $display("FAIL hl_head_stop got=%b exp=11111", stop);
        end
        step();
        n_tests++;
        if (err !== 1'b1 || locked !== 1'b1 || owner !== 3'd1) begin
            n_fail++;
            $display("FAIL hl_err got=%b/%b/%0d exp=1/1/1", err, locked, owner);
        end
        set_in(1, 2'b00, 32'h0);
        #1;
        n_tests++;
        if (stop !== 5'b11111) begin
            n_fail++;
            $display("FAIL hl_bubble_stop got=%b exp=11111", stop);
        end
        step();
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL hl_bubble_lock got=%b exp=1", locked);
        end
        set_in(1, 2'b11, 32'h5100_0002);
        #1;
        n_tests++;
        if (stop !== 5'b11101) begin
            n_fail++;
            $display("FAIL hl_tail_stop got=%b exp=11101", stop);
        end
        sb.push_back(32'h5100_0002);
        step();
        set_in(1, 2'b00, 32'h0);
        #1;
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL hl_idle got=%b exp=0", locked);
        end
        drain("head_locked");
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        set_in(2, 2'b01, 32'h7200_0000);
        #1;
        sb.push_back(32'h7200_0000);
        step();
        set_in(2, 2'b10, 32'h7200_0001);
        #1;
        sb.push_back(32'h7200_0001);
        step();
        set_in(2, 2'b00, 32'h0);
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_pre got=%b/%b exp=1/1", out_valid, locked);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (locked !== 1'b0 || out_valid !== 1'b0 ||
            dut.r_credits !== 4'(D)) begin
            n_fail++;
            $display("FAIL rm_async got=%b/%b/%0d exp=0/0/%0d",
                     locked, out_valid, dut.r_credits, D);
        end
        step();
        step();
        reset = 1'b0;
        set_in(3, 2'b01, 32'h7300_0000);
        #1;
        n_tests++;
        if (stop !== 5'b10111) begin
            n_fail++;
            $display("FAIL rm_new_stop got=%b exp=10111", stop);
        end
        sb.push_back(32'h7300_0000);
        step();
        set_in(3, 2'b00, 32'h0);
        n_tests++;
        if (locked !== 1'b1 || owner !== 3'd3) begin
            n_fail++;
            $display("FAIL rm_new_lock got=%b/%0d exp=1/3", locked, owner);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_exhaust();
        test_credit_same_cycle();
        test_head_while_locked();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
